kb_led_cmd: RTL and testbench
=============================

KB_LED_CMD -- requirements
Module: kb_led_cmd

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2000000, SHALL set the cycles to wait for a keyboard response byte (20 ms at 100 MHz).
REQ-002 Parameter MAX_TRY, default 3, SHALL set the total attempts per sequence before error.
REQ-003 clk  in  1  sole clock; all logic on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 led_req  in  1  one-cycle request to send a new LED state.
REQ-006 led_val  in  3  {caps, num, scroll}, sampled when led_req is accepted.
REQ-007 tx_idle  in  1  PS/2 transmitter ready for a new byte.
REQ-008 tx_done_tick  in  1  one-cycle pulse; transmitter finished the current byte.
REQ-009 rx_done_tick  in  1  one-cycle pulse; received byte valid on din.
REQ-010 din  in  8  received byte from the PS/2 receiver.
REQ-011 wr_ps2  out  1  one-cycle start pulse to the transmitter.
REQ-012 tx_data  out  8  byte to transmit; valid while wr_ps2=1 and held until tx_done_tick.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done_tick  out  1  one-cycle pulse; both bytes acknowledged.
REQ-015 err_tick  out  1  one-cycle pulse; sequence abandoned after MAX_TRY attempts.

Function
REQ-016 The sequence SHALL be: send 0xED, await 0xFA, send {5'b0, led_val_latched}, await 0xFA.
REQ-017 States SHALL be IDLE, SEND_CMD, TX_CMD, ACK_CMD, SEND_ARG, TX_ARG, ACK_ARG.
REQ-018 IDLE -> SEND_CMD on led_req, or on a pending request (REQ-027); led_val latched at that edge; try counter cleared.
REQ-019 SEND_CMD/SEND_ARG: when tx_idle=1, assert wr_ps2 for exactly one cycle with tx_data = 0xED or the argument byte; next state TX_CMD/TX_ARG. If tx_idle=0, wait with no timeout.
REQ-020 TX_x -> ACK_x on tx_done_tick; the timeout counter SHALL be cleared on entry to ACK_x.
REQ-021 ACK_x, rx_done_tick with din=0xFA: ACK_CMD -> SEND_ARG; ACK_ARG -> IDLE with done_tick=1 in the same cycle as the transition.
REQ-022 ACK_x, rx_done_tick with din=0xFE (resend): the current byte SHALL be retransmitted (-> SEND_x); counts as one attempt.
REQ-023 ACK_x, any other received byte SHALL be ignored, with no state change and no timer reset.
REQ-024 ACK_x, timer reaches TIMEOUT_CYC-1 without a valid response: restart at SEND_CMD; counts as one attempt.
REQ-025 The attempt counter SHALL be compared before each retry: if the attempt count equals MAX_TRY, go to IDLE with err_tick=1 instead of retrying.
REQ-026 rx_done_tick and timer expiry in the same cycle: the received byte SHALL take priority.
REQ-027 led_req while busy SHALL set a one-deep pending flag and overwrite a pending value register with led_val. On return to IDLE, the pending request SHALL start the next cycle. A later request overwrites the earlier pending value.
REQ-028 done_tick and err_tick SHALL never both be high; wr_ps2 SHALL be high at most one cycle per transmitted byte.
REQ-029 Timer width SHALL be $clog2(TIMEOUT_CYC); the timer saturates and does not wrap.

Reset
REQ-030 On rst: state=IDLE; wr_ps2=0; tx_data=0x00; busy=0; done_tick=0; err_tick=0; pending flag, latched values, timer and try counter cleared.
REQ-031 rst asserted mid-sequence SHALL abandon the sequence without pulsing done_tick or err_tick; any pending request is lost.

Structure
REQ-032 Shared package: the byte constants 0xED, 0xFA and 0xFE, and the state encoding.
REQ-033 A single sub-module, kb_timeout_cnt (clear/enable/expire), SHALL implement the timer. All other logic SHALL be in one FSM module.

Verification
REQ-034 led_req with led_val=3'b101; model sends 0xFA after each byte -> tx_data 0xED then 0x05, one done_tick, busy low afterwards.
REQ-035 Model answers 0xFE to 0xED once, then 0xFA to both bytes -> 0xED sent twice, 0x05 once, done_tick.
REQ-036 Model silent, TIMEOUT_CYC=100, MAX_TRY=3 -> exactly three 0xED transmissions about 100 cycles apart, then err_tick and IDLE.
REQ-037 Byte 0x1C injected during ACK_CMD, then 0xFA -> 0x1C ignored and sequence completes normally.
REQ-038 led_req 3'b001 then, while busy, led_req 3'b010 and 3'b100 -> two sequences complete, second argument 0x04.
REQ-039 rst asserted in TX_ARG -> all outputs at reset values next cycle, no done_tick or err_tick.

Source files
------------

// File: rtl/kb_led_cmd_pkg.sv
// kb_led_cmd_pkg: PS/2 keyboard LED command bytes and FSM state encoding.
package kb_led_cmd_pkg;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        TX_CMD,
        ACK_CMD,
        SEND_ARG,
        TX_ARG,
        ACK_ARG
    } state_t;
endpackage

// File: rtl/kb_timeout_cnt.sv
// kb_timeout_cnt: saturating response timer; expire flags the last cycle of the wait window.
module kb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int W = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    assign expire = en && cnt == LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/kb_led_cmd.sv
// kb_led_cmd: sends the 0xED set-LED command and its argument to a PS/2 keyboard,
// handling ACK/resend/timeout with bounded retries and a one-deep pending request.
module kb_led_cmd
    import kb_led_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2000000,
    parameter int MAX_TRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       led_req,
    input  logic [2:0] led_val,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] din,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done_tick,
    output logic       err_tick
);
    localparam int TW = $clog2(MAX_TRY + 1);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRY - 1);

    state_t        state;
    logic [2:0]    val;
    logic [2:0]    pend_val;
    logic          pend;
    logic [TW-1:0] tries;
    logic          in_ack;
    logic          expire;
    logic          rsp_ack;
    logic          rsp_resend;

    assign in_ack     = state == ACK_CMD || state == ACK_ARG;
    assign rsp_ack    = rx_done_tick && din == RSP_ACK;
    assign rsp_resend = rx_done_tick && din == RSP_RESEND;

    // Held clear outside the ACK states, so every ACK window starts from zero.
    kb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_ack),
        .en     (in_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            val       <= '0;
            pend_val  <= '0;
            pend      <= 1'b0;
            tries     <= '0;
            wr_ps2    <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            err_tick  <= 1'b0;
        end else begin
            wr_ps2    <= 1'b0;
            done_tick <= 1'b0;
            err_tick  <= 1'b0;
            if (led_req && state != IDLE) begin
                pend     <= 1'b1;
                pend_val <= led_val;
            end
            case (state)
                IDLE: begin
                    if (led_req || pend) begin
                        val   <= led_req ? led_val : pend_val;
                        pend  <= 1'b0;
                        tries <= '0;
                        busy  <= 1'b1;
                        state <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (tx_idle) begin
                        wr_ps2  <= 1'b1;
                        tx_data <= CMD_SET_LED;
                        state   <= TX_CMD;
                    end
                end
                SEND_ARG: begin
                    if (tx_idle) begin
                        wr_ps2  <= 1'b1;
                        tx_data <= {5'b0, val};
                        state   <= TX_ARG;
                    end
                end
                TX_CMD: if (tx_done_tick) state <= ACK_CMD;
                TX_ARG: if (tx_done_tick) state <= ACK_ARG;
                ACK_CMD, ACK_ARG: begin
                    // A valid response wins over a simultaneous timer expiry.
                    if (rsp_ack) begin
                        if (state == ACK_CMD) begin
                            state <= SEND_ARG;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done_tick <= 1'b1;
                        end
                    end else if (rsp_resend || expire) begin
                        if (tries == LAST_TRY) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            err_tick <= 1'b1;
                        end else begin
                            tries <= tries + TW'(1);
                            state <= (rsp_resend && state == ACK_ARG) ? SEND_ARG : SEND_CMD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kb_led_cmd.sv
// tb_kb_led_cmd: scoreboard bench with a reactive keyboard/transmitter model.
module tb_kb_led_cmd;
    localparam int TO = 100;
    localparam int MT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       led_req = 1'b0;
    logic [2:0] led_val = 3'b000;
    logic       tx_idle = 1'b1;
    logic       tx_done_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic       busy;
    logic       done_tick;
    logic       err_tick;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int kicks = 0;
    int served = 0;
    int done_seen = 0;
    int err_seen = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] ev_exp[$];
    logic [9:0] resp_q[$];
    int         ed_times[$];

    kb_led_cmd #(.TIMEOUT_CYC(TO), .MAX_TRY(MT)) dut (
        .clk          (clk),
        .rst          (rst),
        .led_req      (led_req),
        .led_val      (led_val),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .wr_ps2       (wr_ps2),
        .tx_data      (tx_data),
        .busy         (busy),
        .done_tick    (done_tick),
        .err_tick     (err_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every transmitted byte and every done/err pulse is matched against the queues.
    initial begin
        logic [7:0] e;
        logic [7:0] o;
        forever begin
            @(negedge clk);
            if (wr_ps2 === 1'b1) begin
                total++;
                if (tx_exp.size() == 0) begin
                    $display("FAIL tx_byte: unexpected wr_ps2 with tx_data=%h, none required", tx_data);
                end else begin
                    e = tx_exp.pop_front();
                    if (tx_data !== e) $display("FAIL tx_byte: got %h, required %h", tx_data, e);
                    else passed++;
                end
                if (tx_data === 8'hED) ed_times.push_back(cyc);
                kicks++;
            end
            if (done_tick === 1'b1 || err_tick === 1'b1) begin
                total++;
                o = done_tick === 1'b1 ? "D" : "E";
                if (done_tick === 1'b1) done_seen++;
                if (err_tick === 1'b1) err_seen++;
                if (done_tick === 1'b1 && err_tick === 1'b1) begin
                    $display("FAIL tick_excl: done_tick and err_tick both high, required exclusive");
                end else if (ev_exp.size() == 0) begin
                    $display("FAIL end_event: got %s, none required", o);
                end else begin
                    e = ev_exp.pop_front();
                    if (o !== e) $display("FAIL end_event: got %s, required %s", o, e);
                    else passed++;
                end
            end
        end
    end

    // Keyboard + transmitter model; resp bit8 = stay silent, bit9 = send junk 0x1C first.
    initial begin
        logic [9:0] r;
        forever begin
            @(posedge clk);
            if (kicks != served) begin
                served++;
                @(negedge clk) tx_done_tick = 1'b1;
                @(negedge clk) tx_done_tick = 1'b0;
                r = resp_q.size() != 0 ? resp_q.pop_front() : 10'h100;
                if (r[9]) begin
                    repeat (2) @(negedge clk);
                    din = 8'h1C;
                    rx_done_tick = 1'b1;
                    @(negedge clk) rx_done_tick = 1'b0;
                end
                if (!r[8]) begin
                    repeat (2) @(negedge clk);
                    din = r[7:0];
                    rx_done_tick = 1'b1;
                    @(negedge clk) rx_done_tick = 1'b0;
                end
            end
        end
    end

    task automatic req(input logic [2:0] v);
        @(negedge clk);
        led_req = 1'b1;
        led_val = v;
        @(negedge clk);
        led_req = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (n < max_cyc && !(tx_exp.size() == 0 && ev_exp.size() == 0 && busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= max_cyc)
            $display("FAIL %s_timeout: sequence not finished after %0d cycles (tx left %0d, events left %0d, busy %b)",
                     name, n, tx_exp.size(), ev_exp.size(), busy);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (wr_ps2 !== 1'b0) $display("FAIL rst_wr_ps2: got %b, required 0", wr_ps2); else passed++;
        if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h, required 00", tx_data); else passed++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy); else passed++;
        if (done_tick !== 1'b0) $display("FAIL rst_done: got %b, required 0", done_tick); else passed++;
        if (err_tick !== 1'b0) $display("FAIL rst_err: got %b, required 0", err_tick); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int d0 = done_seen;
        int k0;
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h05);
        ev_exp.push_back("D");
        resp_q.push_back(10'h0FA);
        resp_q.push_back(10'h0FA);
        tx_idle = 1'b0;
        req(3'b101);
        k0 = kicks;
        repeat (6) @(negedge clk);
        total += 2;
        if (kicks != k0) $display("FAIL basic_tx_idle_wait: got %0d transmissions while tx_idle=0, required 0", kicks - k0); else passed++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b, required 1", busy); else passed++;
        tx_idle = 1'b1;
        wait_idle(200, "basic");
        total += 2;
        if (done_seen - d0 != 1) $display("FAIL basic_done_count: got %0d, required 1", done_seen - d0); else passed++;
        if (tx_data !== 8'h05) $display("FAIL basic_tx_hold: got %h, required 05", tx_data); else passed++;
    endtask

    task automatic test_resend();
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h05);
        ev_exp.push_back("D");
        resp_q.push_back(10'h0FE);
        resp_q.push_back(10'h0FA);
        resp_q.push_back(10'h0FA);
        req(3'b101);
        wait_idle(300, "resend");
    endtask

    task automatic test_timeout();
        int g;
        ed_times.delete();
        for (int i = 0; i < MT; i++) begin
            tx_exp.push_back(8'hED);
            resp_q.push_back(10'h100);
        end
        ev_exp.push_back("E");
        req(3'b101);
        wait_idle(800, "timeout");
        total++;
        if (ed_times.size() != MT) begin
            $display("FAIL timeout_ed_count: got %0d, required %0d", ed_times.size(), MT);
        end else begin
            passed++;
            for (int i = 1; i < MT; i++) begin
                g = ed_times[i] - ed_times[i-1];
                total++;
                if (g < TO || g > TO + 10) $display("FAIL timeout_gap: got %0d cycles, required %0d..%0d", g, TO, TO + 10);
                else passed++;
            end
        end
    endtask

    task automatic test_junk();
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h03);
        ev_exp.push_back("D");
        resp_q.push_back(10'h2FA);
        resp_q.push_back(10'h0FA);
        req(3'b011);
        wait_idle(200, "junk");
    endtask

    task automatic test_back_to_back();
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h01);
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h04);
        ev_exp.push_back("D");
        ev_exp.push_back("D");
        for (int i = 0; i < 4; i++) resp_q.push_back(10'h0FA);
        req(3'b001);
        repeat (2) @(negedge clk);
        req(3'b010);
        req(3'b100);
        wait_idle(400, "b2b");
    endtask

    task automatic test_reset_mid();
        int d0 = done_seen;
        int e0 = err_seen;
        int n = 0;
        tx_exp.push_back(8'hED);
        tx_exp.push_back(8'h05);
        resp_q.push_back(10'h0FA);
        resp_q.push_back(10'h100);
        req(3'b101);
        req(3'b111);
        while (n < 100 && !(wr_ps2 === 1'b1 && tx_data === 8'h05)) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 100) $display("FAIL rstmid_reach_tx_arg: argument byte not seen in %0d cycles", n); else passed++;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        total += 5;
        if (wr_ps2 !== 1'b0) $display("FAIL rstmid_wr_ps2: got %b, required 0", wr_ps2); else passed++;
        if (tx_data !== 8'h00) $display("FAIL rstmid_tx_data: got %h, required 00", tx_data); else passed++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else passed++;
        if (done_tick !== 1'b0) $display("FAIL rstmid_done: got %b, required 0", done_tick); else passed++;
        if (err_tick !== 1'b0) $display("FAIL rstmid_err: got %b, required 0", err_tick); else passed++;
        @(negedge clk) rst = 1'b0;
        repeat (20) @(negedge clk);
        total += 3;
        if (busy !== 1'b0) $display("FAIL rstmid_pending_lost: busy %b, required 0", busy); else passed++;
        if (done_seen != d0) $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_seen - d0); else passed++;
        if (err_seen != e0) $display("FAIL rstmid_no_err: got %0d pulses, required 0", err_seen - e0); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resend();
        test_timeout();
        test_junk();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
